// File: rtl/clock_divider_prog_if.sv
// Control and status bundle for the programmable clock divider.
// The master side requests ratios and run state; the slave side reports the divided clock.
interface clock_divider_prog_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] div_val;
    logic             div_load;
    logic             clk_out;
    logic             tick;
    logic [WIDTH-1:0] cur_div;
    logic             pending;
    logic             load_err;

    modport master (
        output en, div_val, div_load,
        input  clk_out, tick, cur_div, pending, load_err
    );

    modport slave (
        input  en, div_val, div_load,
        output clk_out, tick, cur_div, pending, load_err
    );
endinterface

// File: rtl/clock_divider_prog.sv
// Runtime-programmable integer clock divider with 50% duty for even and odd ratios.
// Ratio changes and start/stop are applied only at period boundaries.
module clock_divider_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input logic                 clk,
    input logic                 rst,
    clock_divider_prog_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [WIDTH-1:0] pval_q, pval_d;
    logic             pend_q, pend_d;
    logic             pos_q, pos_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             neg_q;

    logic             legal;
    logic             wrap;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] cnt_inc;

    assign legal   = bus.div_load && (bus.div_val >= WIDTH'(2));
    assign wrap    = (cnt_q == cur_q - WIDTH'(1));
    assign half    = cur_q >> 1;
    assign cnt_inc = cnt_q + WIDTH'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        pval_d  = pval_q;
        pend_d  = pend_q;
        pos_d   = 1'b0;
        tick_d  = 1'b0;
        err_d   = bus.div_load && !legal;
        unique case (state_q)
            IDLE: begin
                if (legal) begin
                    cur_d  = bus.div_val;
                    pend_d = 1'b0;
                end else if (bus.en && pend_q) begin
                    cur_d  = pval_q;
                    pend_d = 1'b0;
                end
                if (bus.en) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    tick_d  = 1'b1;
                    pos_d   = 1'b1;
                end
            end
            RUN: begin
                if (wrap) begin
                    cnt_d = '0;
                    if (!bus.en) begin
                        // stop cleanly; a load here waits for the next start
                        state_d = IDLE;
                        if (legal) begin
                            pval_d = bus.div_val;
                            pend_d = 1'b1;
                        end
                    end else begin
                        tick_d = 1'b1;
                        pos_d  = 1'b1;
                        pend_d = 1'b0;
                        if (legal) begin
                            cur_d = bus.div_val;
                        end else if (pend_q) begin
                            cur_d = pval_q;
                        end
                    end
                end else begin
                    cnt_d = cnt_inc;
                    pos_d = (cnt_inc < half);
                    if (legal) begin
                        pval_d = bus.div_val;
                        pend_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cur_q   <= WIDTH'(DEFAULT_DIV);
            pval_q  <= '0;
            pend_q  <= 1'b0;
            pos_q   <= 1'b0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            pval_q  <= pval_d;
            pend_q  <= pend_d;
            pos_q   <= pos_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
        end
    end

    // half-cycle stretch of the high phase for odd ratios
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    assign bus.clk_out  = pos_q | (cur_q[0] & neg_q);
    assign bus.tick     = tick_q;
    assign bus.cur_div  = cur_q;
    assign bus.pending  = pend_q;
    assign bus.load_err = err_q;
endmodule
